// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scan driver.
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_OFF     = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  // Active-low segment patterns, bit order {CA,CB,CC,CD,CE,CF,CG}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // One complete display image: hex word, decimal points, digit enables.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_cfg_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup; ordering is {CA..CG}, low = lit.
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with
// tear-free (frame-boundary) updates and a blanking window per slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  EN,
  input  logic        LOAD,
  output logic        PENDING,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP,
  output logic [7:0]  AN
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam int                IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  disp_cfg_t        shadow_q, shadow_d;
  disp_cfg_t        disp_q, disp_d;
  logic             pending_q, pending_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             blank;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    nibble = disp_q.data[{idx_q, 2'b00} +: 4];
  end

  hex_to_seg7 u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Scan counters: cnt runs every cycle, idx advances at each slot end.
  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Shadow/display handoff: the apply at a frame boundary uses the shadow
  // as it was before that cycle, so a LOAD on the same cycle stays pending.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (LOAD) begin
      shadow_d  = '{data: DATA, dp: DP_IN, en: EN};
      pending_d = 1'b1;
    end
  end

  // Pin values for the current (cnt, idx); registered below.
  always_comb begin
    blank = (cnt_q < BLANK_END) || !disp_q.en[idx_q];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = dec_seg;
      dp_d  = ~disp_q.dp[idx_q];
    end
  end

  // State and output registers with synchronous reset; reset drops any
  // pending update and leaves the display dark.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign PENDING = pending_q;
  assign AN      = an_q;
  assign DP      = dp_q;
  assign CA      = seg_q[6];
  assign CB      = seg_q[5];
  assign CC      = seg_q[4];
  assign CD      = seg_q[3];
  assign CE      = seg_q[2];
  assign CF      = seg_q[1];
  assign CG      = seg_q[0];

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver: a frame-position model pushes the
// expected pins each clock, scenario tasks pop and compare at the negedge.
module tb_seg7_scan_driver;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FR = 8 * TD;
  localparam logic [16:0] DARK = {1'b0, 8'hFF, 7'h7F, 1'b1};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD = 1'b0;
  logic [31:0] DATA = '0;
  logic [7:0]  DP_IN = '0;
  logic [7:0]  EN = '0;
  logic        PENDING, CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb [$];
  logic [16:0] got, exp;

  int          m_t;
  logic [31:0] m_sd, m_dd;
  logic [7:0]  m_sp, m_se, m_dp, m_de;
  logic        m_pend;

  seg7_scan_driver #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .DP_IN(DP_IN), .EN(EN), .LOAD(LOAD),
    .PENDING(PENDING), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF),
    .CG(CG), .DP(DP), .AN(AN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Index of the single low AN bit, -1 if none or more than one.
  function automatic int an_idx(input logic [7:0] a);
    int k = -1;
    int n = 0;
    for (int b = 0; b < 8; b++) if (a[b] === 1'b0) begin k = b; n++; end
    return (n == 1) ? k : -1;
  endfunction

  // Model tracks position within the frame (m_t = 0..FR-1) and the
  // shadow/display images; expected pins come from the pre-edge state.
  always @(posedge CLK) begin : model
    int slot, c;
    logic bnd;
    logic [16:0] e;
    if (RST) begin
      m_t = 0; m_sd = '0; m_sp = '0; m_se = '0;
      m_dd = '0; m_dp = '0; m_de = '0; m_pend = 1'b0;
      e = DARK;
    end else begin
      slot = m_t / TD;
      c    = m_t % TD;
      e    = DARK;
      if (c >= BC && m_de[slot]) begin
        e[15:8] = ~(8'h01 << slot);
        e[7:1]  = seg_of(m_dd[slot*4 +: 4]);
        e[0]    = ~m_dp[slot];
      end
      bnd = (m_t == FR - 1);
      if (bnd && m_pend) begin m_dd = m_sd; m_dp = m_sp; m_de = m_se; end
      if (LOAD) begin m_sd = DATA; m_sp = DP_IN; m_se = EN; m_pend = 1'b1; end
      else if (bnd) m_pend = 1'b0;
      m_t  = (m_t + 1) % FR;
      e[16] = m_pend;
    end
    sb.push_back(e);
  end

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 2*FR + 2; i++) begin
      if (i == 2) RST = 1'b0;
      @(negedge CLK);
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset cyc %0d: got %h expected %h", i, got, exp); end
      checks++;
      if (got !== DARK) begin errors++; $display("FAIL reset_dark cyc %0d: got %h expected %h", i, got, DARK); end
    end
  endtask

  task automatic test_hex();
    int lit [8];
    int nf = -1;
    int k;
    lit = '{default: 0};
    DATA = 32'h76543210; EN = 8'hFF; DP_IN = 8'h00; LOAD = 1'b1;
    for (int i = 0; i < 3*FR; i++) begin
      @(negedge CLK);
      LOAD = 1'b0;
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL hex cyc %0d: got %h expected %h", i, got, exp); end
      if (i == 0) begin
        checks++;
        if (PENDING !== 1'b1) begin errors++; $display("FAIL hex_pending_rise: got %b expected 1", PENDING); end
      end
      if (nf < 0 && PENDING === 1'b0) nf = 0; else if (nf >= 0) nf++;
      if (nf >= 1 && nf <= FR && AN !== 8'hFF) begin
        k = an_idx(AN);
        checks++;
        if (k < 0 || {CA, CB, CC, CD, CE, CF, CG} !== seg_of(k[3:0]) || DP !== 1'b1) begin
          errors++; $display("FAIL hex_digit an %h: got seg %b dp %b", AN, {CA, CB, CC, CD, CE, CF, CG}, DP);
        end else lit[k]++;
        if (AN === 8'hFE) begin
          checks++;
          if ({CA, CB, CC, CD, CE, CF, CG} !== 7'b0000001) begin errors++; $display("FAIL hex_d0: got %b expected 0000001", {CA, CB, CC, CD, CE, CF, CG}); end
        end
        if (AN === 8'h7F) begin
          checks++;
          if ({CA, CB, CC, CD, CE, CF, CG} !== 7'b0001111) begin errors++; $display("FAIL hex_d7: got %b expected 0001111", {CA, CB, CC, CD, CE, CF, CG}); end
        end
      end
    end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (lit[d] !== TD - BC) begin errors++; $display("FAIL hex_lit_cycles digit %0d: got %0d expected %0d", d, lit[d], TD - BC); end
    end
  endtask

  task automatic test_mask();
    int lit [8];
    int nf = -1;
    int k;
    lit = '{default: 0};
    DATA = 32'hFEDCBA98; EN = 8'b0000_0101; DP_IN = 8'b0000_0100; LOAD = 1'b1;
    for (int i = 0; i < 3*FR; i++) begin
      @(negedge CLK);
      LOAD = 1'b0;
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mask cyc %0d: got %h expected %h", i, got, exp); end
      if (nf < 0 && PENDING === 1'b0) nf = 0; else if (nf >= 0) nf++;
      if (nf >= 1 && nf <= FR) begin
        checks++;
        if (AN !== 8'hFF && AN !== 8'hFE && AN !== 8'hFB) begin errors++; $display("FAIL mask_an: got %h expected FF/FE/FB", AN); end
        k = an_idx(AN);
        if (k >= 0) lit[k]++;
        if (AN === 8'hFE) begin
          checks++;
          if ({CA, CB, CC, CD, CE, CF, CG, DP} !== 8'b0000000_1) begin errors++; $display("FAIL mask_d0: got %b expected 00000001", {CA, CB, CC, CD, CE, CF, CG, DP}); end
        end
        if (AN === 8'hFB) begin
          checks++;
          if ({CA, CB, CC, CD, CE, CF, CG, DP} !== 8'b0001000_0) begin errors++; $display("FAIL mask_d2: got %b expected 00010000", {CA, CB, CC, CD, CE, CF, CG, DP}); end
        end
      end
    end
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (lit[d] !== ((d == 0 || d == 2) ? TD - BC : 0)) begin errors++; $display("FAIL mask_lit_cycles digit %0d: got %0d", d, lit[d]); end
    end
  endtask

  task automatic test_back_to_back();
    int ph = 0;
    int nf = -1;
    int lit = 0;
    for (int i = 0; i < 4*FR; i++) begin
      LOAD = 1'b0;
      if (ph == 0 && m_t == 4) begin
        DATA = 32'h11111111; EN = 8'hFF; DP_IN = 8'h00; LOAD = 1'b1; ph = 1;
      end else if (ph == 1 && m_t == 12) begin
        DATA = 32'h22222222; LOAD = 1'b1; ph = 2;
      end
      @(negedge CLK);
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b cyc %0d: got %h expected %h", i, got, exp); end
      checks++;
      if (AN === 8'hFD && {CA, CB, CC, CD, CE, CF, CG} === 7'b1001111) begin errors++; $display("FAIL b2b_stale: digit 1 got 1001111 expected not shown"); end
      if (ph == 2) begin
        if (nf < 0 && PENDING === 1'b0) nf = 0; else if (nf >= 0) nf++;
      end
      if (nf >= 1 && nf <= FR && AN !== 8'hFF) begin
        lit++; checks++;
        if ({CA, CB, CC, CD, CE, CF, CG} !== 7'b0010010) begin errors++; $display("FAIL b2b_two an %h: got %b expected 0010010", AN, {CA, CB, CC, CD, CE, CF, CG}); end
      end
    end
    LOAD = 1'b0;
    checks++;
    if (lit !== 8*(TD - BC)) begin errors++; $display("FAIL b2b_lit_cycles: got %0d expected %0d", lit, 8*(TD - BC)); end
  endtask

  task automatic test_boundary_load();
    int ph = 0;
    int n = -1;
    for (int i = 0; i < 4*FR; i++) begin
      LOAD = 1'b0;
      if (ph == 0 && m_t == 10) begin
        DATA = 32'h33333333; EN = 8'hFF; DP_IN = 8'h00; LOAD = 1'b1; ph = 1;
      end else if (ph == 1 && m_t == FR - 1) begin
        DATA = 32'h44444444; LOAD = 1'b1; ph = 2;
      end
      @(negedge CLK);
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL bnd cyc %0d: got %h expected %h", i, got, exp); end
      if (ph == 2) n++;
      if (n == 0 || n == FR - 1) begin
        checks++;
        if (PENDING !== 1'b1) begin errors++; $display("FAIL bnd_pending_held n %0d: got %b expected 1", n, PENDING); end
      end
      if (n == FR) begin
        checks++;
        if (PENDING !== 1'b0) begin errors++; $display("FAIL bnd_pending_fall: got %b expected 0", PENDING); end
      end
      if (n >= 1 && n <= 2*FR && AN !== 8'hFF) begin
        checks++;
        if ({CA, CB, CC, CD, CE, CF, CG} !== ((n <= FR) ? 7'b0000110 : 7'b1001100)) begin
          errors++; $display("FAIL bnd_value n %0d: got %b", n, {CA, CB, CC, CD, CE, CF, CG});
        end
      end
    end
    LOAD = 1'b0;
  endtask

  task automatic test_reset_mid();
    int ph = 0;
    int n = -1;
    for (int i = 0; i < 3*FR; i++) begin
      LOAD = 1'b0;
      RST  = 1'b0;
      if (ph == 0 && m_t == 21) begin
        DATA = 32'h88888888; EN = 8'hFF; DP_IN = 8'hFF; LOAD = 1'b1; ph = 1;
      end else if (ph == 1 && m_t == 27) begin
        RST = 1'b1; ph = 2;
      end
      @(negedge CLK);
      got = {PENDING, AN, CA, CB, CC, CD, CE, CF, CG, DP};
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rstmid cyc %0d: got %h expected %h", i, got, exp); end
      if (ph == 2) n++;
      if (n == 0) begin
        checks++;
        if (AN !== 8'hFF || PENDING !== 1'b0) begin errors++; $display("FAIL rstmid_clear: got an %h pending %b expected FF 0", AN, PENDING); end
      end
      if (n >= 0) begin
        checks++;
        if (got !== DARK) begin errors++; $display("FAIL rstmid_dark n %0d: got %h expected %h", n, got, DARK); end
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hex();
    test_mask();
    test_back_to_back();
    test_boundary_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
